// File: rtl/imem_loader.sv
// Program-load stage: clears and fills the byte-addressed instruction memory from a
// byte-serial stream, then serves the fetch stage a 10-byte window at f_PC.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    input  logic              reload,
    input  logic [63:0]       f_PC,
    output logic [79:0]       instr_bytes,
    output logic              imem_error,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned  WIN_BYTES = 10;
    localparam logic [63:0]  LAST_PC   = 64'(MEM_BYTES - WIN_BYTES);
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_run_q, cpu_run_d;
    logic                load_err_q, load_err_d;

    logic [7:0]          mem [MEM_BYTES];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [7:0]          mem_wdata;

    // Next-state, counter and memory-write decode
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = 8'h00;
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + ADDR_W'(1);
                if (ptr_q == TOP_ADDR) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = wptr_q;
                    mem_wdata = in_byte;
                    wptr_d    = wptr_q + ADDR_W'(1);
                    count_d   = count_q + (ADDR_W+1)'(1);
                    if (in_last) begin
                        state_d = DONE;
                    end else if (wptr_q == TOP_ADDR) begin
                        state_d = ERR;
                    end
                end
            end
            DONE, ERR: begin
                if (reload) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    wptr_d  = '0;
                    count_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
        in_ready_d = (state_d == LOAD);
        cpu_run_d  = (state_d == DONE);
        load_err_d = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            cpu_run_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            cpu_run_q  <= cpu_run_d;
            load_err_q <= load_err_d;
        end
    end

    // Memory is never reset; the CLEAR state wipes it instead
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign imem_error = cpu_run_q & (f_PC > LAST_PC);

    // Window index only used after the range check, so wrap-around never shows
    always_comb begin
        logic [ADDR_W-1:0] idx;
        idx         = '0;
        instr_bytes = '0;
        for (int k = 0; k < int'(WIN_BYTES); k++) begin
            idx = f_PC[ADDR_W-1:0] + ADDR_W'(k);
            if (cpu_run_q && !imem_error) begin
                instr_bytes[8*k +: 8] = mem[idx];
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign cpu_run    = cpu_run_q;
    assign load_err   = load_err_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear timing, loads, throttling, overflow,
// fetch-window range checks and mid-load reset.
module tb_imem_loader;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_byte;
    logic         in_last;
    logic         reload;
    logic [63:0]  f_PC;
    logic [79:0]  instr_bytes;
    logic         imem_error;
    logic         cpu_run;
    logic         load_err;
    logic [10:0]  byte_count;

    int checks = 0;
    int errors = 0;

    imem_loader #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .in_last     (in_last),
        .reload      (reload),
        .f_PC        (f_PC),
        .instr_bytes (instr_bytes),
        .imem_error  (imem_error),
        .cpu_run     (cpu_run),
        .load_err    (load_err),
        .byte_count  (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until in_ready rises; drops in_valid as soon as it does
    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 2000) begin
            tick();
            cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (guard >= 100) check("send_timeout", 80'(guard), 80'd0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'h55;
        in_last  = 1'b0;
        reload   = 1'b0;
        f_PC     = 64'd0;

        // Reset and the initial 1024-cycle clear
        tick();
        tick();
        check("rst_ready", 80'(in_ready), 80'd0);
        check("rst_run", 80'(cpu_run), 80'd0);
        check("rst_err", 80'(load_err), 80'd0);
        check("rst_count", 80'(byte_count), 80'd0);
        rst_n = 1'b1;
        wait_clear(cnt);
        check("clear_len", 80'(cnt), 80'd1024);
        check("clear_count", 80'(byte_count), 80'd0);
        check("clear_run", 80'(cpu_run), 80'd0);

        // 11-byte program
        send_byte(8'h30, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'hF2, 1'b0);
        send_byte(8'h0A, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        check("prog_count", 80'(byte_count), 80'd11);
        check("prog_run", 80'(cpu_run), 80'd1);
        check("prog_ready", 80'(in_ready), 80'd0);
        f_PC = 64'd0; #1;
        check("pc0_byte0", 80'(instr_bytes[7:0]), 80'h30);
        check("pc0_byte2", 80'(instr_bytes[23:16]), 80'hF2);
        check("pc0_win", instr_bytes, 80'h0000_0000_0000_0AF2_0030);
        f_PC = 64'd1; #1;
        check("pc1_win", instr_bytes, 80'h0000_0000_0000_000A_F200);
        f_PC = 64'd11; #1;
        check("pc11_win", instr_bytes, 80'd0);
        check("pc11_err", 80'(imem_error), 80'd0);

        // Reload from DONE: in_valid on the reload cycle is ignored
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        pulse_reload();
        in_valid = 1'b0;
        check("rl_run", 80'(cpu_run), 80'd0);
        check("rl_count", 80'(byte_count), 80'd0);
        wait_clear(cnt);
        check("rl_clear_len", 80'(cnt), 80'd1024);
        check("rl_count2", 80'(byte_count), 80'd0);

        // Throttled stream: valid every other cycle
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_byte  = 8'hA0 + 8'(i / 2);
            tick();
        end
        in_valid = 1'b0;
        check("thr_count", 80'(byte_count), 80'd4);
        send_byte(8'hA4, 1'b1);
        check("thr_count5", 80'(byte_count), 80'd5);
        f_PC = 64'd0; #1;
        check("thr_win", instr_bytes, 80'h0000_0000_00A4_A3A2_A1A0);

        // Overflow: 1024 bytes without in_last
        pulse_reload();
        wait_clear(cnt);
        check("ov_clear_len", 80'(cnt), 80'd1024);
        in_valid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            in_byte = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("ov_err", 80'(load_err), 80'd1);
        check("ov_run", 80'(cpu_run), 80'd0);
        check("ov_ready", 80'(in_ready), 80'd0);
        check("ov_count", 80'(byte_count), 80'd1024);
        f_PC = 64'd0; #1;
        check("ov_win", instr_bytes, 80'd0);
        pulse_reload();
        check("ov_rl_err", 80'(load_err), 80'd0);
        wait_clear(cnt);
        check("ov_rl_clear", 80'(cnt), 80'd1024);

        // Full 1024-byte program with in_last on the top byte
        in_valid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            in_byte = 8'(i);
            in_last = (i == 1023);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("full_run", 80'(cpu_run), 80'd1);
        check("full_err", 80'(load_err), 80'd0);
        check("full_count", 80'(byte_count), 80'd1024);
        f_PC = 64'd1014; #1;
        check("pc1014_err", 80'(imem_error), 80'd0);
        check("pc1014_win", instr_bytes, 80'hFFFE_FDFC_FBFA_F9F8_F7F6);
        f_PC = 64'd1015; #1;
        check("pc1015_err", 80'(imem_error), 80'd1);
        check("pc1015_win", instr_bytes, 80'd0);
        f_PC = 64'hFFFF_FFFF_FFFF_FFF8; #1;
        check("pchuge_err", 80'(imem_error), 80'd1);
        check("pchuge_win", instr_bytes, 80'd0);

        // Reset in the middle of a load
        pulse_reload();
        wait_clear(cnt);
        for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i), 1'b0);
        check("mid_count5", 80'(byte_count), 80'd5);
        rst_n = 1'b0;
        tick();
        check("mid_rst_count", 80'(byte_count), 80'd0);
        check("mid_rst_ready", 80'(in_ready), 80'd0);
        check("mid_rst_run", 80'(cpu_run), 80'd0);
        rst_n = 1'b1;
        wait_clear(cnt);
        check("mid_clear_len", 80'(cnt), 80'd1024);
        send_byte(8'h10, 1'b1);
        check("mid_count1", 80'(byte_count), 80'd1);
        f_PC = 64'd0; #1;
        check("mid_win", instr_bytes, 80'h0000_0000_0000_0000_0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
